cmult_mac: RTL and testbench

//  Parametrised, fully pipelined complex multiply / multiply-accumulate with valid qualification.

---
 rtl/cmult_mac_if.sv | 30 +++
 rtl/cmult_mac.sv | 149 ++++++++++++++
 tb/tb_cmult_mac.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmult_mac_if.sv
// rtl/cmult_mac_if.sv - sample and result bundle for the complex multiply / MAC
interface cmult_mac_if #(
    parameter int XW = 18,
    parameter int YW = 18,
    parameter int ZW = 48
);
    logic                 in_valid;
    logic signed [XW-1:0] xr;
    logic signed [XW-1:0] xi;
    logic signed [YW-1:0] yr;
    logic signed [YW-1:0] yi;
    logic                 conj;
    logic                 in_first;
    logic                 in_last;
    logic                 out_valid;
    logic signed [ZW-1:0] zr;
    logic signed [ZW-1:0] zi;
    logic                 sat;
    logic                 ovf_sticky;

    modport master (
        output in_valid, xr, xi, yr, yi, conj, in_first, in_last,
        input  out_valid, zr, zi, sat, ovf_sticky
    );

    modport slave (
        input  in_valid, xr, xi, yr, yi, conj, in_first, in_last,
        output out_valid, zr, zi, sat, ovf_sticky
    );
endinterface

// File: rtl/cmult_mac.sv
// rtl/cmult_mac.sv - pipelined complex multiply / multiply-accumulate with round, shift, saturate
module cmult_mac #(
    parameter int XW        = 18,
    parameter int YW        = 18,
    parameter int ZW        = 48,
    parameter int SHIFT     = 0,
    parameter int ACCUM     = 0,
    parameter int ACC_GUARD = 8
) (
    input  logic       clk,
    input  logic       rst,
    cmult_mac_if.slave bus
);
    localparam int PW = XW + YW;
    localparam int AW = PW + 1 + ACC_GUARD;
    // Rounding constant 2^(SHIFT-1); zero when no shift is applied.
    localparam logic signed [AW:0] HALF =
        (SHIFT > 0) ? ((AW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic                 s1_valid;
    logic signed [XW-1:0] s1_xr, s1_xi;
    logic signed [YW-1:0] s1_yr, s1_yi;
    logic                 s1_conj, s1_first, s1_last;

    logic                 s2_valid;
    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
    logic                 s2_conj, s2_first, s2_last;

    logic signed [AW-1:0] prod_r, prod_i, base_r, base_i, nxt_r, nxt_i;
    logic                 emit;
    logic signed [AW-1:0] acc_r, acc_i;
    logic                 s3_valid;
    logic signed [AW-1:0] s3_r, s3_i;

    logic signed [AW:0]   ext_r, ext_i, rnd_r, rnd_i;
    logic signed [ZW-1:0] zr_c, zi_c;
    logic                 clip_r, clip_i;

    // S1: capture the sample and its controls.
    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= bus.in_valid;
        s1_xr    <= bus.xr;
        s1_xi    <= bus.xi;
        s1_yr    <= bus.yr;
        s1_yi    <= bus.yi;
        s1_conj  <= bus.conj;
        s1_first <= bus.in_first;
        s1_last  <= bus.in_last;
    end

    // S2: the four full-precision partial products.
    always_ff @(posedge clk) begin
        if (rst) s2_valid <= 1'b0;
        else     s2_valid <= s1_valid;
        p_rr     <= s1_xr * s1_yr;
        p_ii     <= s1_xi * s1_yi;
        p_ir     <= s1_xi * s1_yr;
        p_ri     <= s1_xr * s1_yi;
        s2_conj  <= s1_conj;
        s2_first <= s1_first;
        s2_last  <= s1_last;
    end

    // S3 combine: conj(y) flips the sign of the imaginary part of y; without
    // accumulation the base is always zero so the sum is just the product.
    always_comb begin
        prod_r = s2_conj ? (AW'(p_rr) + AW'(p_ii)) : (AW'(p_rr) - AW'(p_ii));
        prod_i = s2_conj ? (AW'(p_ir) - AW'(p_ri)) : (AW'(p_ir) + AW'(p_ri));
        base_r = (ACCUM != 0 && !s2_first) ? acc_r : '0;
        base_i = (ACCUM != 0 && !s2_first) ? acc_i : '0;
        nxt_r  = base_r + prod_r;
        nxt_i  = base_i + prod_i;
        emit   = (ACCUM != 0) ? s2_last : 1'b1;
    end

    // S3: accumulator update on valid samples, forward when the sum is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            acc_r    <= '0;
            acc_i    <= '0;
            s3_r     <= '0;
            s3_i     <= '0;
        end else begin
            s3_valid <= s2_valid & emit;
            if (s2_valid) begin
                acc_r <= nxt_r;
                acc_i <= nxt_i;
                s3_r  <= nxt_r;
                s3_i  <= nxt_i;
            end
        end
    end

    // S4 combine: round half up, arithmetic shift; one guard bit absorbs the rounding carry.
    always_comb begin
        ext_r = {s3_r[AW-1], s3_r};
        ext_i = {s3_i[AW-1], s3_i};
        rnd_r = (ext_r + HALF) >>> SHIFT;
        rnd_i = (ext_i + HALF) >>> SHIFT;
    end

    generate
        if (ZW <= AW) begin : g_clip
            localparam logic [ZW-1:0] ZMAX = {1'b0, {(ZW-1){1'b1}}};
            localparam logic [ZW-1:0] ZMIN = {1'b1, {(ZW-1){1'b0}}};
            logic hi_r, lo_r, hi_i, lo_i;
            // Out of range when the bits above the output sign disagree with it.
            always_comb begin
                hi_r   = !rnd_r[AW] && (|rnd_r[AW:ZW-1]);
                lo_r   = rnd_r[AW] && !(&rnd_r[AW:ZW-1]);
                hi_i   = !rnd_i[AW] && (|rnd_i[AW:ZW-1]);
                lo_i   = rnd_i[AW] && !(&rnd_i[AW:ZW-1]);
                zr_c   = hi_r ? ZMAX : (lo_r ? ZMIN : rnd_r[ZW-1:0]);
                zi_c   = hi_i ? ZMAX : (lo_i ? ZMIN : rnd_i[ZW-1:0]);
                clip_r = hi_r | lo_r;
                clip_i = hi_i | lo_i;
            end
        end else begin : g_wide
            // Output wide enough for any value: plain sign extension.
            always_comb begin
                zr_c   = ZW'(rnd_r);
                zi_c   = ZW'(rnd_i);
                clip_r = 1'b0;
                clip_i = 1'b0;
            end
        end
    endgenerate

    // S4: result registers; values hold between strobes, sat only on a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.zr         <= '0;
            bus.zi         <= '0;
            bus.sat        <= 1'b0;
            bus.ovf_sticky <= 1'b0;
        end else begin
            bus.out_valid <= s3_valid;
            bus.sat       <= s3_valid & (clip_r | clip_i);
            if (s3_valid) begin
                bus.zr <= zr_c;
                bus.zi <= zi_c;
            end
            if (s3_valid & (clip_r | clip_i)) bus.ovf_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cmult_mac.sv
// tb/tb_cmult_mac.sv - self-checking bench for cmult_mac against an arithmetic reference model
module tb_cmult_mac;
    typedef struct {
        longint zr;
        longint zi;
        bit     sat;
        int     due;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    exp_t   q[3][$];
    bit     stk[3];
    longint acc_r = 0;
    longint acc_i = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a: 18x18 -> 48, no shift; b: 16x16 -> 16, shift 15; c: 16x16 -> 36 accumulating
    cmult_mac_if #(.XW(18), .YW(18), .ZW(48)) a_if ();
    cmult_mac_if #(.XW(16), .YW(16), .ZW(16)) b_if ();
    cmult_mac_if #(.XW(16), .YW(16), .ZW(36)) c_if ();

    cmult_mac #(.XW(18), .YW(18), .ZW(48), .SHIFT(0), .ACCUM(0), .ACC_GUARD(8))
        u_a (.clk(clk), .rst(rst), .bus(a_if));
    cmult_mac #(.XW(16), .YW(16), .ZW(16), .SHIFT(15), .ACCUM(0), .ACC_GUARD(8))
        u_b (.clk(clk), .rst(rst), .bus(b_if));
    cmult_mac #(.XW(16), .YW(16), .ZW(36), .SHIFT(0), .ACCUM(1), .ACC_GUARD(8))
        u_c (.clk(clk), .rst(rst), .bus(c_if));

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    function automatic longint rsat(input longint v, input int sh, input int zw, output bit clip);
        longint hi, lo, t;
        hi = (longint'(1) <<< (zw - 1)) - 1;
        lo = -hi - 1;
        t  = v;
        if (sh > 0) t = (t + (longint'(1) <<< (sh - 1))) >>> sh;
        clip = 1'b0;
        if (t > hi) begin
            clip = 1'b1;
            t = hi;
        end else if (t < lo) begin
            clip = 1'b1;
            t = lo;
        end
        return t;
    endfunction

    function automatic longint wrap41(input longint v);
        longint t;
        t = v <<< 23;
        return t >>> 23;
    endfunction

    function automatic void cmul(input longint xr, input longint xi, input longint yr,
                                 input longint yi, input bit cj,
                                 output longint pr, output longint pi);
        pr = cj ? (xr * yr + xi * yi) : (xr * yr - xi * yi);
        pi = cj ? (xi * yr - xr * yi) : (xi * yr + xr * yi);
    endfunction

    function automatic int rnd_s(input int w);
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    endfunction

    task automatic push(input int id, input longint r, input longint i);
        exp_t e;
        bit   c1, c2;
        int   sh, zw;
        sh = (id == 1) ? 15 : 0;
        zw = (id == 0) ? 48 : ((id == 1) ? 16 : 36);
        e.zr  = rsat(r, sh, zw, c1);
        e.zi  = rsat(i, sh, zw, c2);
        e.sat = c1 | c2;
        e.due = cyc + 4;
        q[id].push_back(e);
    endtask

    task automatic mon(input int id, input string tag, input bit ov, input longint zr,
                       input longint zi, input bit sat, input bit ovf);
        exp_t e;
        if (ov) begin
            if (q[id].size() == 0) begin
                check({tag, "_spurious_out"}, 1, 0);
            end else begin
                e = q[id].pop_front();
                stk[id] = stk[id] | e.sat;
                check({tag, "_zr"}, zr, e.zr);
                check({tag, "_zi"}, zi, e.zi);
                check({tag, "_sat"}, longint'(sat), longint'(e.sat));
                check({tag, "_latency"}, longint'(cyc), longint'(e.due));
                check({tag, "_ovf"}, longint'(ovf), longint'(stk[id]));
            end
        end else begin
            check({tag, "_sat_idle"}, longint'(sat), 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, "a", a_if.out_valid, longint'(a_if.zr), longint'(a_if.zi), a_if.sat, a_if.ovf_sticky);
        mon(1, "b", b_if.out_valid, longint'(b_if.zr), longint'(b_if.zi), b_if.sat, b_if.ovf_sticky);
        mon(2, "c", c_if.out_valid, longint'(c_if.zr), longint'(c_if.zi), c_if.sat, c_if.ovf_sticky);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_valid();
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        c_if.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            clr_valid();
        end
    endtask

    task automatic send_a(input int xr, input int xi, input int yr, input int yi, input bit cj);
        longint pr, pi;
        tick();
        clr_valid();
        a_if.in_valid = 1'b1;
        a_if.xr = 18'(xr);
        a_if.xi = 18'(xi);
        a_if.yr = 18'(yr);
        a_if.yi = 18'(yi);
        a_if.conj = cj;
        a_if.in_first = 1'($urandom);
        a_if.in_last = 1'($urandom);
        cmul(xr, xi, yr, yi, cj, pr, pi);
        push(0, pr, pi);
    endtask

    task automatic send_b(input int xr, input int xi, input int yr, input int yi, input bit cj);
        longint pr, pi;
        tick();
        clr_valid();
        b_if.in_valid = 1'b1;
        b_if.xr = 16'(xr);
        b_if.xi = 16'(xi);
        b_if.yr = 16'(yr);
        b_if.yi = 16'(yi);
        b_if.conj = cj;
        b_if.in_first = 1'($urandom);
        b_if.in_last = 1'($urandom);
        cmul(xr, xi, yr, yi, cj, pr, pi);
        push(1, pr, pi);
    endtask

    task automatic send_c(input int xr, input int xi, input int yr, input int yi, input bit cj,
                          input bit f, input bit l);
        longint pr, pi;
        tick();
        clr_valid();
        c_if.in_valid = 1'b1;
        c_if.xr = 16'(xr);
        c_if.xi = 16'(xi);
        c_if.yr = 16'(yr);
        c_if.yi = 16'(yi);
        c_if.conj = cj;
        c_if.in_first = f;
        c_if.in_last = l;
        cmul(xr, xi, yr, yi, cj, pr, pi);
        if (f) begin
            acc_r = pr;
            acc_i = pi;
        end else begin
            acc_r = wrap41(acc_r + pr);
            acc_i = wrap41(acc_i + pi);
        end
        if (l) push(2, acc_r, acc_i);
    endtask

    // One-cycle reset: everything not yet visible at the outputs is dropped.
    task automatic pulse_reset();
        tick();
        clr_valid();
        rst = 1'b1;
        for (int id = 0; id < 3; id++) begin
            while (q[id].size() > 0 && q[id][$].due > cyc) void'(q[id].pop_back());
            stk[id] = 1'b0;
        end
        acc_r = 0;
        acc_i = 0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        a_if.in_valid = 0; a_if.xr = 0; a_if.xi = 0; a_if.yr = 0; a_if.yi = 0;
        a_if.conj = 0; a_if.in_first = 0; a_if.in_last = 0;
        b_if.in_valid = 0; b_if.xr = 0; b_if.xi = 0; b_if.yr = 0; b_if.yi = 0;
        b_if.conj = 0; b_if.in_first = 0; b_if.in_last = 0;
        c_if.in_valid = 0; c_if.xr = 0; c_if.xi = 0; c_if.yr = 0; c_if.yi = 0;
        c_if.conj = 0; c_if.in_first = 0; c_if.in_last = 0;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_a_out_valid", longint'(a_if.out_valid), 0);
        check("rst_a_zr", longint'(a_if.zr), 0);
        check("rst_a_zi", longint'(a_if.zi), 0);
        check("rst_a_ovf", longint'(a_if.ovf_sticky), 0);
        check("rst_c_out_valid", longint'(c_if.out_valid), 0);
        check("rst_c_zr", longint'(c_if.zr), 0);
        check("rst_c_sat", longint'(c_if.sat), 0);
        rst = 1'b0;

        // plain product, exact latency
        send_a(3, 4, 1, 2, 0);
        idle(3);
        check("t1_early_out_valid", longint'(a_if.out_valid), 0);
        idle(1);
        check("t1_out_valid", longint'(a_if.out_valid), 1);
        check("t1_zr", longint'(a_if.zr), -5);
        check("t1_zi", longint'(a_if.zi), 10);
        check("t1_sat", longint'(a_if.sat), 0);

        // conjugate, then alternating conj back to back
        send_a(3, 4, 1, 2, 1);
        idle(4);
        check("t2_zr", longint'(a_if.zr), 11);
        check("t2_zi", longint'(a_if.zi), -2);
        for (int i = 0; i < 6; i++) send_a(3, 4, 1, 2, 1'(i));
        idle(5);

        // rounding and saturation at 16 bits with shift 15
        send_b(-32768, 0, -32768, 0, 0);
        idle(4);
        check("t3_sat_zr", longint'(b_if.zr), 32767);
        check("t3_sat_flag", longint'(b_if.sat), 1);
        check("t3_sat_ovf", longint'(b_if.ovf_sticky), 1);
        send_b(1, 0, 16384, 0, 0);
        idle(4);
        check("t3_half_up_zr", longint'(b_if.zr), 1);
        check("t3_half_up_sat", longint'(b_if.sat), 0);
        send_b(-1, 0, 16384, 0, 0);
        idle(4);
        check("t3_neg_half_zr", longint'(b_if.zr), 0);
        check("t3_ovf_held", longint'(b_if.ovf_sticky), 1);

        // framed accumulation with an idle gap, then a single-sample frame
        send_c(1, 1, 1, 0, 0, 1, 0);
        send_c(1, 1, 1, 0, 0, 0, 0);
        idle(1);
        send_c(1, 1, 1, 0, 0, 0, 0);
        send_c(1, 1, 1, 0, 0, 0, 1);
        idle(4);
        check("t4_out_valid", longint'(c_if.out_valid), 1);
        check("t4_zr", longint'(c_if.zr), 4);
        check("t4_zi", longint'(c_if.zi), 4);
        send_c(2, 0, 3, 0, 0, 1, 1);
        idle(4);
        check("t4_single_zr", longint'(c_if.zr), 6);
        check("t4_single_zi", longint'(c_if.zi), 0);

        // random full-scale stream with gaps, conj and framing
        for (int i = 0; i < 1000; i++) begin
            if ($urandom % 4 == 0) idle(1 + int'($urandom % 3));
            send_c(rnd_s(16), rnd_s(16), rnd_s(16), rnd_s(16), 1'($urandom),
                   ($urandom % 4) == 0, ($urandom % 4) == 0);
            if (i % 4 == 0) send_a(rnd_s(18), rnd_s(18), rnd_s(18), rnd_s(18), 1'($urandom));
            if (i % 5 == 0) send_b(rnd_s(16), rnd_s(16), rnd_s(16), rnd_s(16), 1'($urandom));
        end
        idle(6);

        // reset with samples in flight and an open accumulation
        send_c(5, 0, 1, 0, 0, 1, 0);
        send_c(7, 0, 1, 0, 0, 0, 0);
        send_b(-32768, 0, -32768, 0, 0);
        pulse_reset();
        check("t6_b_ovf", longint'(b_if.ovf_sticky), 0);
        check("t6_c_ovf", longint'(c_if.ovf_sticky), 0);
        check("t6_c_out_valid", longint'(c_if.out_valid), 0);
        idle(8);
        check("t6_b_ovf_after", longint'(b_if.ovf_sticky), 0);
        send_c(2, 0, 3, 0, 0, 1, 0);
        send_c(1, 0, 1, 0, 0, 0, 1);
        idle(4);
        check("t6_out_valid", longint'(c_if.out_valid), 1);
        check("t6_zr", longint'(c_if.zr), 7);
        check("t6_zi", longint'(c_if.zi), 0);

        idle(8);
        check("a_pending", longint'(q[0].size()), 0);
        check("b_pending", longint'(q[1].size()), 0);
        check("c_pending", longint'(q[2].size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
